// File: rtl/rcastudioii_ioctl_upload.sv
// Upload responder for hps_io: answers ioctl_rd byte requests from the shared RAM,
// stalling the HPS with ioctl_wait while the RAM read is arbitrated and in flight.
module rcastudioii_ioctl_upload #(
    parameter int         MEM_AW     = 11,
    parameter int         RAM_LAT    = 1,
    parameter logic [7:0] UPLOAD_IDX = 8'h01,
    parameter logic [7:0] FILL       = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_q,
    output logic [15:0]       bytes_sent,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [24:0] WIN = 25'(2 ** MEM_AW);

    state_t            state, state_nx;
    logic [1:0]        cnt, cnt_nx;
    logic [7:0]        din_nx;
    logic              wait_nx;
    logic              rd_nx;
    logic [MEM_AW-1:0] addr_nx;
    logic [15:0]       sent_nx;
    logic              err_nx;
    logic              upload_q;
    logic              hit;
    logic              rise;
    logic              in_win;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hit    = ioctl_rd && (ioctl_index == UPLOAD_IDX);
    assign rise   = ioctl_upload && !upload_q;
    assign in_win = ioctl_addr < WIN;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        din_nx   = ioctl_din;
        wait_nx  = ioctl_wait;
        rd_nx    = mem_rd;
        addr_nx  = mem_addr;
        sent_nx  = bytes_sent;
        err_nx   = proto_err;
        case (state)
            IDLE: begin
                if (ioctl_upload && hit) begin
                    if (in_win) begin
                        addr_nx  = ioctl_addr[MEM_AW-1:0];
                        wait_nx  = 1'b1;
                        rd_nx    = 1'b1;
                        state_nx = REQ;
                    end else begin
                        // Beyond the RAM window: answer immediately, no RAM cycle.
                        din_nx  = FILL;
                        sent_nx = sat_inc(bytes_sent);
                    end
                end
            end
            REQ: begin
                if (hit) err_nx = 1'b1;
                if (!ioctl_upload) begin
                    state_nx = IDLE;
                    wait_nx  = 1'b0;
                    rd_nx    = 1'b0;
                end else if (mem_gnt) begin
                    rd_nx    = 1'b0;
                    cnt_nx   = 2'(RAM_LAT);
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (hit) err_nx = 1'b1;
                if (!ioctl_upload) begin
                    state_nx = IDLE;
                    wait_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        din_nx   = mem_q;
                        wait_nx  = 1'b0;
                        sent_nx  = sat_inc(bytes_sent);
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                wait_nx  = 1'b0;
                rd_nx    = 1'b0;
            end
        endcase
        // A new transfer restarts the statistics, even over a same-cycle completion.
        if (rise) begin
            sent_nx = 16'd0;
            err_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            ioctl_din  <= 8'd0;
            ioctl_wait <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            bytes_sent <= 16'd0;
            proto_err  <= 1'b0;
            upload_q   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            ioctl_din  <= din_nx;
            ioctl_wait <= wait_nx;
            mem_rd     <= rd_nx;
            mem_addr   <= addr_nx;
            bytes_sent <= sent_nx;
            proto_err  <= err_nx;
            upload_q   <= ioctl_upload;
        end
    end

endmodule

// File: tb/tb_rcastudioii_ioctl_upload.sv
// Bench for rcastudioii_ioctl_upload: transaction-level model plus RAM/arbiter
// environment, directed scenarios and a randomized phase.
module tb_rcastudioii_ioctl_upload;

    localparam int         MEM_AW     = 11;
    localparam int         RAM_LAT    = 1;
    localparam logic [7:0] UPLOAD_IDX = 8'h01;
    localparam logic [7:0] FILL       = 8'hFF;
    localparam int         MEM_SZ     = 2 ** MEM_AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_gnt;
    logic [7:0]        mem_q;
    logic [15:0]       bytes_sent;
    logic              proto_err;

    rcastudioii_ioctl_upload #(
        .MEM_AW(MEM_AW), .RAM_LAT(RAM_LAT), .UPLOAD_IDX(UPLOAD_IDX), .FILL(FILL)
    ) dut (
        .clk(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_gnt(mem_gnt),
        .mem_q(mem_q), .bytes_sent(bytes_sent), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic [7:0] ram [0:MEM_SZ-1];

    // RAM environment: one outstanding read, data presented RAM_LAT cycles after grant.
    logic              memv  = 1'b0;
    int                memcd = 0;
    logic [MEM_AW-1:0] mema  = '0;

    // Transaction-level expectation.
    logic              m_busy = 1'b0;
    logic              m_gr   = 1'b0;
    int                m_left = 0;
    logic [MEM_AW-1:0] m_addr = '0;
    logic [7:0]        m_din  = 8'd0;
    logic [15:0]       m_sent = 16'd0;
    logic              m_err  = 1'b0;
    logic              m_upq  = 1'b0;

    int wait_cnt = 0;
    int rd_cnt   = 0;

    always @(posedge clk) begin
        logic hit;
        if (memv) begin
            if (memcd == 0) memv = 1'b0;
            else memcd--;
        end
        if (mem_rd && mem_gnt) begin
            memv  = 1'b1;
            memcd = RAM_LAT - 1;
            mema  = mem_addr;
        end

        if (reset) begin
            m_busy = 1'b0; m_gr = 1'b0; m_addr = '0; m_din = 8'd0;
            m_sent = 16'd0; m_err = 1'b0; m_upq = 1'b0;
        end else begin
            hit = ioctl_rd && (ioctl_index == UPLOAD_IDX);
            if (!m_busy) begin
                if (ioctl_upload && hit) begin
                    if (ioctl_addr < 25'(MEM_SZ)) begin
                        m_busy = 1'b1;
                        m_gr   = 1'b0;
                        m_addr = ioctl_addr[MEM_AW-1:0];
                    end else begin
                        m_din = FILL;
                        if (m_sent != 16'hFFFF) m_sent++;
                    end
                end
            end else begin
                if (hit) m_err = 1'b1;
                if (!ioctl_upload) m_busy = 1'b0;
                else if (!m_gr) begin
                    if (mem_gnt) begin
                        m_gr   = 1'b1;
                        m_left = RAM_LAT;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_din  = ram[m_addr];
                        m_busy = 1'b0;
                        if (m_sent != 16'hFFFF) m_sent++;
                    end
                end
            end
            if (ioctl_upload && !m_upq) begin
                m_sent = 16'd0;
                m_err  = 1'b0;
            end
            m_upq = ioctl_upload;
        end

        #1;
        chk("din", ioctl_din, m_din);
        chk("wait", ioctl_wait, m_busy);
        chk("mem_rd", mem_rd, m_busy && !m_gr);
        chk("mem_addr", mem_addr, m_addr);
        chk("bytes_sent", bytes_sent, m_sent);
        chk("proto_err", proto_err, m_err);
        if (ioctl_wait) wait_cnt++;
        if (mem_rd) rd_cnt++;
    end

    int   gnt_block = 0;
    logic gnt_rand  = 1'b0;

    task automatic next();
        @(negedge clk);
        ioctl_rd = 1'b0;
        if (gnt_block > 0) begin
            mem_gnt = 1'b0;
            gnt_block--;
        end else begin
            mem_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        mem_q = (memv && memcd == 0) ? ram[mema] : 8'($urandom);
    endtask

    task automatic do_read(input logic [24:0] a, output logic [7:0] d);
        int n;
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        next();
        n = 0;
        while (ioctl_wait && n < 100) begin
            next();
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL rd_timeout: addr %0h still waiting after %0d cycles, required completion", a, n);
        end
        d = ioctl_din;
    endtask

    task automatic new_upload();
        ioctl_upload = 1'b0;
        next();
        ioctl_upload = 1'b1;
        next();
    endtask

    initial begin
        logic [7:0]  d;
        logic [7:0]  din_prev;
        logic [15:0] b;

        for (int i = 0; i < MEM_SZ; i++) ram[i] = 8'($urandom);
        ram[11'h010] = 8'hA5;
        reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = UPLOAD_IDX;
        ioctl_rd = 1'b0; ioctl_addr = '0; mem_gnt = 1'b1; mem_q = 8'h00;
        next(); next(); next();
        chk("rst_din", ioctl_din, 8'h00);
        chk("rst_wait", ioctl_wait, 1'b0);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_bytes", bytes_sent, 16'd0);
        chk("rst_err", proto_err, 1'b0);
        reset = 1'b0;
        next();

        // Immediate grant, RAM_LAT=1.
        ioctl_upload = 1'b1;
        next();
        wait_cnt = 0; rd_cnt = 0;
        do_read(25'h010, d);
        chk("t1_din", d, 8'hA5);
        chk("t1_wait_cycles", wait_cnt, 2);
        chk("t1_bytes", bytes_sent, 16'd1);

        // Grant withheld for five cycles.
        ram[11'h123] = 8'h3C;
        gnt_block = 5; wait_cnt = 0;
        do_read(25'h123, d);
        chk("t2_din", d, 8'h3C);
        chk("t2_wait_cycles", wait_cnt, 7);

        // Outside the RAM window, including high bits that must not wrap.
        wait_cnt = 0; rd_cnt = 0;
        do_read(25'h800, d);
        chk("t3_din", d, 8'hFF);
        chk("t3_wait_cycles", wait_cnt, 0);
        chk("t3_rd_cycles", rd_cnt, 0);
        do_read(25'h1000010, d);
        chk("t3_nowrap_din", d, 8'hFF);
        chk("t3_bytes", bytes_sent, 16'd4);

        // Foreign index gets no response.
        ioctl_index = 8'h02; wait_cnt = 0;
        ioctl_rd = 1'b1; ioctl_addr = 25'h010;
        next(); next();
        chk("idx_wait_cycles", wait_cnt, 0);
        chk("idx_bytes", bytes_sent, 16'd4);
        ioctl_index = UPLOAD_IDX;

        // Second strobe during DATA.
        ram[11'h020] = 8'h77;
        ioctl_rd = 1'b1; ioctl_addr = 25'h020;
        next(); next();
        ioctl_rd = 1'b1; ioctl_addr = 25'h030;
        next();
        chk("t4_err", proto_err, 1'b1);
        chk("t4_din", ioctl_din, 8'h77);
        chk("t4_bytes", bytes_sent, 16'd5);
        new_upload();
        chk("t4_err_clr", proto_err, 1'b0);
        chk("t4_bytes_clr", bytes_sent, 16'd0);

        // Upload dropped in REQ.
        b = bytes_sent; din_prev = ioctl_din;
        gnt_block = 3; ioctl_rd = 1'b1; ioctl_addr = 25'h040;
        next();
        ioctl_upload = 1'b0;
        next();
        chk("t6_req_wait", ioctl_wait, 1'b0);
        chk("t6_req_rd", mem_rd, 1'b0);
        chk("t6_req_bytes", bytes_sent, b);
        ioctl_upload = 1'b1;
        next();

        // Upload dropped in DATA.
        do_read(25'h010, d);
        din_prev = ioctl_din; b = bytes_sent;
        ram[11'h050] = din_prev ^ 8'h5A;
        ioctl_rd = 1'b1; ioctl_addr = 25'h050;
        next(); next();
        ioctl_upload = 1'b0;
        next();
        chk("t6_data_wait", ioctl_wait, 1'b0);
        chk("t6_data_din", ioctl_din, din_prev);
        chk("t6_data_bytes", bytes_sent, b);
        ioctl_upload = 1'b1;
        next();

        // Reset in REQ and in DATA.
        do_read(25'h010, d);
        gnt_block = 3; ioctl_rd = 1'b1; ioctl_addr = 25'h060;
        next();
        reset = 1'b1;
        next();
        chk("t6_rst_req_wait", ioctl_wait, 1'b0);
        chk("t6_rst_req_rd", mem_rd, 1'b0);
        chk("t6_rst_req_bytes", bytes_sent, 16'd0);
        reset = 1'b0;
        next();
        do_read(25'h010, d);
        ioctl_rd = 1'b1; ioctl_addr = 25'h050;
        next(); next();
        reset = 1'b1;
        next();
        chk("t6_rst_data_wait", ioctl_wait, 1'b0);
        chk("t6_rst_data_din", ioctl_din, 8'h00);
        chk("t6_rst_data_bytes", bytes_sent, 16'd0);
        reset = 1'b0;
        next();

        // Full image upload with random grant gaps.
        gnt_rand = 1'b1;
        new_upload();
        for (int a = 0; a < MEM_SZ; a++) begin
            do_read(25'(a), d);
            if (d !== ram[a]) chk("t5_stream", d, ram[a]);
        end
        chk("t5_bytes", bytes_sent, 16'd2048);
        chk("t5_err", proto_err, 1'b0);

        // Randomized protocol traffic, checked cycle by cycle.
        for (int i = 0; i < 3000; i++) begin
            next();
            reset        = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) ioctl_upload = ~ioctl_upload;
            ioctl_index  = ($urandom_range(0, 9) == 0) ? 8'h02 : UPLOAD_IDX;
            ioctl_rd     = ($urandom_range(0, 3) == 0);
            ioctl_addr   = ($urandom_range(0, 7) == 0) ? 25'($urandom) : 25'($urandom_range(0, MEM_SZ - 1));
        end
        reset = 1'b0; ioctl_upload = 1'b1;
        next(); next(); next(); next();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
